corral_host: RTL and testbench

Host-side master for the Corral game chip pins. It issues one player move per command by pulsing `enter` with a 3-bit move. It then captures the chip's fixed-length reply frame: cowboy position nibble, horse position nibble, and status bits. The captured frame is returned as one response word. The block sits on the board/FPGA side, driving the chip's `enter`/`move`/reset pins and receiving its `ready`/`lostwon`/`gameover`/`data` pins on the same clock.

---
 rtl/corral_host.sv | 206 ++++++++++++++++++++
 tb/tb_corral_host.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corral_host.sv
// Host-side master for the Corral game chip: issues one move per command,
// captures the chip's cowboy/horse/status reply frame and returns it as a response.
module corral_host #(
  parameter int READY_TIMEOUT = 255,
  parameter int RESET_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_move,
  output logic       cmd_ready,
  input  logic       new_game,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_cowboy,
  output logic [3:0] rsp_horse,
  output logic       rsp_gameover,
  output logic       rsp_lostwon,
  output logic       rsp_timeout,
  output logic       game_over,
  output logic [7:0] move_count,
  output logic       enter,
  output logic [2:0] move,
  output logic       chip_reset,
  input  logic       chip_ready,
  input  logic       chip_lostwon,
  input  logic       chip_gameover,
  input  logic [3:0] chip_data
);

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready, and rsp_valid
  // with all rsp_* fields stays stable until that edge.

  typedef enum logic [3:0] {
    S_CHIP_RST  = 4'd0,
    S_IDLE      = 4'd1,
    S_WAIT_RDY  = 4'd2,
    S_ENTER     = 4'd3,
    S_CAP_COW   = 4'd4,
    S_CAP_HORSE = 4'd5,
    S_CAP_STAT  = 4'd6,
    S_RESP      = 4'd7,
    S_OVER      = 4'd8
  } state_t;

  // One counter serves both the chip reset pulse and the ready wait.
  localparam logic [15:0] RST_LAST_C = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST_C  = 16'(READY_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  move_lat_q, move_lat_d;
  logic        enter_q, enter_d;
  logic [2:0]  move_q, move_d;
  logic        chip_reset_q, chip_reset_d;
  logic [3:0]  cow_q, cow_d;
  logic [3:0]  horse_q, horse_d;
  logic        go_q, go_d;
  logic        lw_q, lw_d;
  logic        to_q, to_d;
  logic        game_over_q, game_over_d;
  logic [7:0]  move_count_q, move_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    move_lat_d   = move_lat_q;
    cow_d        = cow_q;
    horse_d      = horse_q;
    go_d         = go_q;
    lw_d         = lw_q;
    to_d         = to_q;
    game_over_d  = game_over_q;
    move_count_d = move_count_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;

    case (state_q)
      S_CHIP_RST: begin
        if (cnt_q == RST_LAST_C) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          game_over_d  = 1'b0;
          move_count_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        cmd_ready = !new_game;
        if (new_game) begin
          state_d = S_CHIP_RST;
          cnt_d   = '0;
        end else if (cmd_valid) begin
          move_lat_d = cmd_move;
          cnt_d      = '0;
          state_d    = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (chip_ready) begin
          state_d = S_ENTER;
        end else if (cnt_q == TO_LAST_C) begin
          // Abort: the response carries only the timeout flag.
          cow_d   = '0;
          horse_d = '0;
          go_d    = 1'b0;
          lw_d    = 1'b0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ENTER: begin
        state_d = S_CAP_COW;
      end
      S_CAP_COW: begin
        cow_d   = chip_data;
        state_d = S_CAP_HORSE;
      end
      S_CAP_HORSE: begin
        horse_d = chip_data;
        state_d = S_CAP_STAT;
      end
      S_CAP_STAT: begin
        go_d = chip_gameover;
        lw_d = chip_lostwon;
        to_d = 1'b0;
        if (move_count_q != 8'hFF) begin
          move_count_d = move_count_q + 8'd1;
        end
        if (chip_gameover) begin
          game_over_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = game_over_q ? S_OVER : S_IDLE;
        end
      end
      S_OVER: begin
        if (new_game) begin
          state_d = S_CHIP_RST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CHIP_RST;
        cnt_d   = '0;
      end
    endcase

    // Chip pin drives are registered from the next state so they line up with it.
    chip_reset_d = (state_d == S_CHIP_RST);
    enter_d      = (state_d == S_ENTER);
    move_d       = enter_d ? move_lat_q : 3'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CHIP_RST;
      cnt_q        <= '0;
      move_lat_q   <= '0;
      enter_q      <= 1'b0;
      move_q       <= '0;
      chip_reset_q <= 1'b1;
      cow_q        <= '0;
      horse_q      <= '0;
      go_q         <= 1'b0;
      lw_q         <= 1'b0;
      to_q         <= 1'b0;
      game_over_q  <= 1'b0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      move_lat_q   <= move_lat_d;
      enter_q      <= enter_d;
      move_q       <= move_d;
      chip_reset_q <= chip_reset_d;
      cow_q        <= cow_d;
      horse_q      <= horse_d;
      go_q         <= go_d;
      lw_q         <= lw_d;
      to_q         <= to_d;
      game_over_q  <= game_over_d;
      move_count_q <= move_count_d;
    end
  end

  assign rsp_cowboy   = cow_q;
  assign rsp_horse    = horse_q;
  assign rsp_gameover = go_q;
  assign rsp_lostwon  = lw_q;
  assign rsp_timeout  = to_q;
  assign game_over    = game_over_q;
  assign move_count   = move_count_q;
  assign enter        = enter_q;
  assign move         = move_q;
  assign chip_reset   = chip_reset_q;

endmodule

// File: tb/tb_corral_host.sv
// Bench for corral_host: table vectors, hand-written corner sequences and a
// randomized move stream checked against a simple game/frame model.
module tb_corral_host;

  localparam int NEVER = 1000;
  localparam int TMO   = 255;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid, new_game, rsp_ready;
  logic [2:0] cmd_move;
  logic       cmd_ready, rsp_valid;
  logic [3:0] rsp_cowboy, rsp_horse;
  logic       rsp_gameover, rsp_lostwon, rsp_timeout, game_over;
  logic [7:0] move_count;
  logic       enter, chip_reset;
  logic [2:0] move;
  logic       chip_ready, chip_lostwon, chip_gameover;
  logic [3:0] chip_data;

  int vectors = 0;
  int miscompares = 0;

  corral_host #(.READY_TIMEOUT(TMO), .RESET_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_move(cmd_move), .cmd_ready(cmd_ready),
    .new_game(new_game), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cowboy(rsp_cowboy), .rsp_horse(rsp_horse),
    .rsp_gameover(rsp_gameover), .rsp_lostwon(rsp_lostwon), .rsp_timeout(rsp_timeout),
    .game_over(game_over), .move_count(move_count),
    .enter(enter), .move(move), .chip_reset(chip_reset),
    .chip_ready(chip_ready), .chip_lostwon(chip_lostwon),
    .chip_gameover(chip_gameover), .chip_data(chip_data)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Chip model: after the enter pulse, reply with cowboy, horse, then status,
  // one value per cycle; junk everywhere else so mistimed captures show up.
  logic [3:0] chip_cow, chip_horse;
  logic       chip_go, chip_lw;
  int         ph = 0;
  int         enters = 0;
  int         bad_enter = 0;
  int         bad_move = 0;
  logic [2:0] seen_move = 3'd0;
  logic       prev_enter = 1'b0;

  always @(negedge clock) begin
    chip_data     = 4'($urandom_range(0, 15));
    chip_gameover = 1'($urandom_range(0, 1));
    chip_lostwon  = 1'($urandom_range(0, 1));
    if (ph == 1) chip_data = chip_cow;
    if (ph == 2) chip_data = chip_horse;
    if (ph == 3) begin
      chip_gameover = chip_go;
      chip_lostwon  = chip_lw;
    end
    if (!reset_n) ph = 0;
    else if (enter) begin
      enters++;
      seen_move = move;
      if (prev_enter) bad_enter++;
      ph = 1;
    end else if (ph != 0 && ph < 3) ph++;
    else ph = 0;
    if (!enter && move != 3'd0) bad_move++;
    prev_enter = enter;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] mv;
    logic [3:0] cw, hs;
    logic       go, lw;
    int         d, hold;
    logic [3:0] e_cw, e_hs;
    logic       e_go, e_lw, e_to;
    int         e_cnt, e_lat;
  } vec_t;

  // Called at a negedge from IDLE; returns at a negedge after the response is taken.
  task automatic do_move(input vec_t v);
    int lat;
    int n;
    int e0;
    logic [31:0] exp_f;
    e0 = enters;
    exp_f = 32'({v.e_cw, v.e_hs, v.e_go, v.e_lw, v.e_to});
    chip_cow = v.cw; chip_horse = v.hs; chip_go = v.go; chip_lw = v.lw;
    chip_ready = (v.d == 0);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1;
    cmd_move  = v.mv;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_move  = 3'($urandom_range(0, 7));
    lat = 1;
    while (!rsp_valid && lat < 600) begin
      if (lat == v.d) chip_ready = 1'b1;
      @(negedge clock);
      lat++;
    end
    chk("rsp_latency", lat, v.e_lat);
    chk("rsp_fields", 32'({rsp_cowboy, rsp_horse, rsp_gameover, rsp_lostwon, rsp_timeout}), exp_f);
    for (int i = 0; i < v.hold; i++) begin
      new_game = (i == 3);
      @(negedge clock);
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      chk("hold_fields", 32'({rsp_cowboy, rsp_horse, rsp_gameover, rsp_lostwon, rsp_timeout}), exp_f);
      chk("hold_chip_reset", 32'(chip_reset), 32'(0));
    end
    new_game  = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'(0));
    chk("move_count", 32'(move_count), v.e_cnt);
    chk("game_over", 32'(game_over), 32'(v.e_go));
    chk("enter_pulses", enters - e0, v.e_to ? 0 : 1);
    if (!v.e_to) chk("enter_move", 32'(seen_move), 32'(v.mv));
  endtask

  vec_t tbl[5];
  vec_t rv;
  int   mc;
  int   rsp_seen;

  initial begin
    tbl[0] = '{3'd5, 4'h3, 4'h9, 1'b0, 1'b0, 0, 0, 4'h3, 4'h9, 1'b0, 1'b0, 1'b0, 1, 6};
    tbl[1] = '{3'd0, 4'h0, 4'hF, 1'b0, 1'b1, 2, 0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2, 7};
    tbl[2] = '{3'd7, 4'hA, 4'h5, 1'b0, 1'b0, NEVER, 1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2, TMO + 1};
    tbl[3] = '{3'd2, 4'hF, 4'h0, 1'b0, 1'b1, 1, 10, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 3, 6};
    tbl[4] = '{3'd6, 4'hC, 4'hD, 1'b1, 1'b1, 0, 0, 4'hC, 4'hD, 1'b1, 1'b1, 1'b0, 4, 6};

    // Clock/reset block
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_move = 3'd0; new_game = 1'b0;
    rsp_ready = 1'b0; chip_ready = 1'b0;
    chip_cow = 4'h0; chip_horse = 4'h0; chip_go = 1'b0; chip_lw = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_chip_reset", 32'(chip_reset), 32'(1));
    chk("rst_handshakes", 32'({cmd_ready, rsp_valid, enter, move}), 32'(0));
    chk("rst_status", 32'({game_over, move_count}), 32'(0));
    chk("rst_fields", 32'({rsp_cowboy, rsp_horse, rsp_gameover, rsp_lostwon, rsp_timeout}), 32'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      chk("boot_chip_reset", 32'(chip_reset), 32'(i <= 4));
    end
    chk("boot_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("boot_status", 32'({game_over, move_count}), 32'(0));

    // Table vectors; the last one ends the game.
    for (int k = 0; k < 5; k++) do_move(tbl[k]);

    // Game over: commands refused until new_game, which pulses chip_reset.
    n_over_check();

    // Randomized stream against the model, long enough to saturate move_count.
    mc = 0;
    for (int i = 0; i < 280; i++) begin
      rv.mv = 3'($urandom_range(0, 7));
      rv.cw = 4'($urandom_range(0, 15));
      rv.hs = 4'($urandom_range(0, 15));
      rv.go = 1'b0;
      rv.lw = 1'($urandom_range(0, 1));
      rv.d  = (i % 50 == 25) ? NEVER : $urandom_range(0, 3);
      rv.hold = $urandom_range(0, 2);
      rv.e_to = (rv.d == NEVER);
      rv.e_cw = rv.e_to ? 4'h0 : rv.cw;
      rv.e_hs = rv.e_to ? 4'h0 : rv.hs;
      rv.e_lw = rv.e_to ? 1'b0 : rv.lw;
      rv.e_go = 1'b0;
      if (!rv.e_to && mc < 255) mc++;
      rv.e_cnt = mc;
      rv.e_lat = rv.e_to ? TMO + 1 : (rv.d <= 1 ? 6 : 5 + rv.d);
      do_move(rv);
    end
    chk("saturated_count", 32'(move_count), 32'(255));

    // Reset asserted while the horse nibble is being captured.
    chip_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_move  = 3'd3;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_chip_reset", 32'(chip_reset), 32'(1));
    chk("mid_rst_handshakes", 32'({cmd_ready, rsp_valid, enter, move}), 32'(0));
    chk("mid_rst_status", 32'({game_over, move_count}), 32'(0));
    chk("mid_rst_fields", 32'({rsp_cowboy, rsp_horse, rsp_gameover, rsp_lostwon, rsp_timeout}), 32'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rsp_valid) rsp_seen++;
    end
    chk("mid_rst_no_response", rsp_seen, 0);
    chk("mid_rst_idle", 32'(cmd_ready), 32'(1));

    chk("enter_width", bad_enter, 0);
    chk("move_zero_when_idle", bad_move, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic n_over_check();
    int e0;
    chk("over_game_over", 32'(game_over), 32'(1));
    e0 = enters;
    cmd_valid = 1'b1;
    cmd_move  = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("over_cmd_ready", 32'(cmd_ready), 32'(0));
    end
    cmd_valid = 1'b0;
    chk("over_no_enter", enters - e0, 0);
    new_game = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      new_game = 1'b0;
      chk("ng_chip_reset", 32'(chip_reset), 32'(i <= 4));
    end
    chk("ng_status", 32'({game_over, move_count}), 32'(0));
    chk("ng_cmd_ready", 32'(cmd_ready), 32'(1));
  endtask

endmodule
